cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Three-state fetch/execute controller for the 16-bit CPU.
- Fetches 16-bit instructions from a 4K-word program memory over a req/valid handshake.
- Decodes the 4-bit opcode and drives the external combinational ALU.
- Holds the A/B/C registers and the flag register; sits between program memory and the ALU datapath.

Parameters:
- DATA_WIDTH, 16, data/instruction width.
- ADDRESS_WIDTH, 12, program counter / memory address width.
- OPCODE, 4, opcode field width, instruction bits [15:12].
- ALU_FLAG_WIDTH, 5, flag vector width {carry, zero, equal, larger, lower}.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leave idle (RESET state) and begin fetching.
- halt_req  in  1  return to idle after the current instruction.
- mem_req  out  1  instruction read request.
- mem_addr  out  ADDRESS_WIDTH  read address (= pc).
- mem_rdata  in  DATA_WIDTH  instruction word, valid when mem_rvalid=1.
- mem_rvalid  in  1  read data valid, 1-cycle pulse, latency ≥1.
- alu_op  out  OPCODE  opcode to the ALU (enum_alu_opcode_t).
- alu_a  out  DATA_WIDTH  operand A (= reg A).
- alu_b  out  DATA_WIDTH  operand B (= reg B).
- alu_result  in  DATA_WIDTH  ALU result, combinational from alu_op/alu_a/alu_b.
- alu_flags  in  ALU_FLAG_WIDTH  ALU flags (struct_alu_flag_t).
- state_o  out  3  current state (enum_CPU_state_t).
- pc_o  out  ADDRESS_WIDTH  program counter.
- reg_c_o  out  DATA_WIDTH  accumulator C.
- flags_o  out  ALU_FLAG_WIDTH  latched flags.
- busy  out  1  1 when state != RESET.

Behaviour:
- Reset (rst_n=0, asynchronous): state=RESET, pc=0, IR=0, A=B=C=0, flags=0, mem_req=0. All outputs are 0.
- Instruction format: [15:12] opcode, [11:0] imm12.
- RESET (idle): mem_req=0. If start=1 at a clock edge, go to LOAD. Registers and pc are held, so a restart resumes at the current pc.
- LOAD:
  - mem_req=1 and mem_addr=pc, held stable until mem_rvalid.
  - On the mem_rvalid edge: IR<=mem_rdata, pc<=pc+1 (4095 wraps to 0), go to EXECUTE.
  - mem_rvalid in any state other than LOAD is ignored.
  - mem_req deasserts in the cycle after rvalid.
- EXECUTE (exactly 1 cycle):
  - alu_op=IR[15:12]; alu_a=A, alu_b=B.
  - Opcodes 0000–1100 (ADD..NOTA): C<=alu_result, flags<=alu_flags. A and B are unchanged.
  - LOADA: A<={4'b0,imm12}. LOADB: B<={4'b0,imm12}. LOADC: C<={4'b0,imm12}. Flags are unchanged for all three loads.
  - Next state: RESET if halt_req=1 at this edge, else LOAD.
- halt_req:
  - Sampled only in EXECUTE; the current instruction always completes.
  - halt_req in LOAD does not abort the pending fetch.
- start is ignored outside RESET. If start and halt_req are both 1 in EXECUTE, halt wins.
- alu_op outside EXECUTE is driven 0 (ADD); the ALU output is not consumed then.
- Throughput: one instruction per (fetch latency + 1 EXECUTE + 1 LOAD-issue) cycles. Minimum is 3 cycles/instruction with latency 1.
- Reset asserted mid-fetch or mid-execute: immediate return to reset values. The pending read is abandoned; a later rvalid is ignored because state=RESET.
- Widths: the ALU result is truncated to DATA_WIDTH (the ALU's responsibility). imm12 is zero-extended, never sign-extended.

Test Plan:
- Reset/idle: hold rst_n=0, then release with start=0 for 10 cycles → state=RESET, mem_req=0, pc=0, busy=0 throughout.
- Load/add: memory {0:LOADA 0x005, 1:LOADB 0x003, 2:ADD}, latency 1, start pulse → after 9 cycles C=0x0008, pc=3, flags.zero=0. alu_op=0000 only in the ADD EXECUTE cycle.
- Variable latency: same program with rvalid delayed 4 cycles → mem_req and mem_addr stay stable until rvalid; final result is identical (C=0x0008).
- Halt/resume: halt_req=1 during the EXECUTE of instruction 1 → state=RESET after it, pc=2, A/B retained. A start pulse then fetches address 2.
- PC wrap: preload pc=0xFFF via a program filling memory with LOADC, run one instruction at 0xFFF → pc=0x000 and the next mem_addr=0x000.
- Async reset mid-fetch: drop rst_n while mem_req=1, deliver rvalid after reset release → IR is not loaded, state=RESET, all registers 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Three-state fetch/execute controller: fetches instructions over a
//            req/valid handshake, drives the external ALU, holds A/B/C/flags.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 12,
  parameter int OPCODE         = 4,
  parameter int ALU_FLAG_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      halt_req,
  output logic                      mem_req,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_rvalid,
  output logic [OPCODE-1:0]         alu_op,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [ALU_FLAG_WIDTH-1:0] alu_flags,
  output logic [2:0]                state_o,
  output logic [ADDRESS_WIDTH-1:0]  pc_o,
  output logic [DATA_WIDTH-1:0]     reg_c_o,
  output logic [ALU_FLAG_WIDTH-1:0] flags_o,
  output logic                      busy
);

  localparam int c_imm_w = DATA_WIDTH - OPCODE;

  localparam logic [2:0] c_st_reset   = 3'd0;
  localparam logic [2:0] c_st_load    = 3'd1;
  localparam logic [2:0] c_st_execute = 3'd2;

  localparam logic [OPCODE-1:0] c_op_add   = 4'b0000;
  localparam logic [OPCODE-1:0] c_op_loada = 4'b1101;
  localparam logic [OPCODE-1:0] c_op_loadb = 4'b1110;
  localparam logic [OPCODE-1:0] c_op_loadc = 4'b1111;

  logic [2:0]                r_state;
  logic [2:0]                w_state_next;
  logic [ADDRESS_WIDTH-1:0]  r_pc;
  logic [DATA_WIDTH-1:0]     r_ir;
  logic [DATA_WIDTH-1:0]     r_a;
  logic [DATA_WIDTH-1:0]     r_b;
  logic [DATA_WIDTH-1:0]     r_c;
  logic [ALU_FLAG_WIDTH-1:0] r_flags;

  logic                      w_mem_req;
  logic [OPCODE-1:0]         w_alu_op;
  logic [OPCODE-1:0]         w_ir_op;
  logic [DATA_WIDTH-1:0]     w_imm_ext;

  assign w_ir_op   = r_ir[DATA_WIDTH-1 -: OPCODE];
  assign w_imm_ext = {{OPCODE{1'b0}}, r_ir[c_imm_w-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_reset;
    end else begin
      r_state <= w_state_next;
    end
  end

  // halt_req is only looked at in EXECUTE, so a pending fetch always completes
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_reset:   if (start)      w_state_next = c_st_load;
      c_st_load:    if (mem_rvalid) w_state_next = c_st_execute;
      c_st_execute: w_state_next = halt_req ? c_st_reset : c_st_load;
      default:      w_state_next = c_st_reset;
    endcase
  end

  always_comb begin
    w_mem_req = 1'b0;
    w_alu_op  = c_op_add;
    case (r_state)
      c_st_load:    w_mem_req = 1'b1;
      c_st_execute: w_alu_op  = w_ir_op;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        c_st_load: begin
          if (mem_rvalid) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        c_st_execute: begin
          case (w_ir_op)
            c_op_loada: r_a <= w_imm_ext;
            c_op_loadb: r_b <= w_imm_ext;
            c_op_loadc: r_c <= w_imm_ext;
            default: begin
              r_c     <= alu_result;
              r_flags <= alu_flags;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mem_req  = w_mem_req;
  assign mem_addr = r_pc;
  assign alu_op   = w_alu_op;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign state_o  = r_state;
  assign pc_o     = r_pc;
  assign reg_c_o  = r_c;
  assign flags_o  = r_flags;
  assign busy     = (r_state != c_st_reset);

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Brief    : Directed, table-driven bench with a latency-programmable memory
//            responder and a small combinational ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_flags;
  logic [2:0]  state_o;
  logic [11:0] pc_o;
  logic [15:0] reg_c_o;
  logic [4:0]  flags_o;
  logic        busy;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(12), .OPCODE(4), .ALU_FLAG_WIDTH(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags), .state_o(state_o),
    .pc_o(pc_o), .reg_c_o(reg_c_o), .flags_o(flags_o), .busy(busy)
  );

  // ALU model: flags = {carry, zero, equal, larger, lower}
  logic [16:0] sum17;
  logic        carry;
  always_comb begin
    sum17      = {1'b0, alu_a} + {1'b0, alu_b};
    carry      = 1'b0;
    alu_result = alu_a;
    case (alu_op)
      4'd0:  begin alu_result = sum17[15:0]; carry = sum17[16]; end
      4'd1:  begin alu_result = alu_a - alu_b; carry = (alu_a < alu_b); end
      4'd2:  alu_result = alu_a & alu_b;
      4'd3:  alu_result = alu_a | alu_b;
      4'd4:  alu_result = alu_a ^ alu_b;
      4'd12: alu_result = ~alu_a;
      default: alu_result = alu_a;
    endcase
    alu_flags = {carry, alu_result == 16'h0, alu_a == alu_b, alu_a > alu_b, alu_a < alu_b};
  end

  // Memory responder: rvalid pulses lat cycles after the request-issue cycle
  logic [15:0] mem [0:4095];
  int          lat = 1;
  int          wait_cnt = 0;
  logic        auto_en = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_data = 16'h0;
  logic        man_valid = 1'b0;
  logic [15:0] man_data = 16'h0;

  assign mem_rvalid = rsp_valid | man_valid;
  assign mem_rdata  = man_valid ? man_data : rsp_data;

  always @(negedge clk) begin
    if (rsp_valid || !mem_req || !auto_en) begin
      rsp_valid <= 1'b0;
      wait_cnt  <= 0;
    end else if (wait_cnt + 1 > lat) begin
      rsp_valid <= 1'b1;
      rsp_data  <= mem[mem_addr];
      wait_cnt  <= 0;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Background monitors, evaluated once at the end
  int          aluop_bad = 0;
  int          addr_bad = 0;
  logic        prev_req = 1'b0;
  logic [11:0] prev_addr = 12'h0;
  always @(negedge clk) begin
    if (state_o != 3'd2 && alu_op != 4'd0) aluop_bad <= aluop_bad + 1;
    if (prev_req && mem_req && mem_addr != prev_addr) addr_bad <= addr_bad + 1;
    prev_req  <= mem_req;
    prev_addr <= mem_addr;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start from idle, run n instructions and halt (with start also high) in the last EXECUTE
  task automatic run(input int n, input int lat_i, input logic [11:0] exp_addr, output int cycles);
    int cnt;
    int cyc;
    lat = lat_i;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("fetch_req", {31'b0, mem_req}, 32'd1);
    check("fetch_addr", {20'b0, mem_addr}, {20'b0, exp_addr});
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < n * (lat_i + 2) + 16) begin
      if (state_o == 3'd2) begin
        cnt++;
        if (cnt == n) begin halt_req = 1'b1; start = 1'b1; end
      end
      @(negedge clk);
      cyc++;
    end
    halt_req = 1'b0;
    start    = 1'b0;
    check("exec_count", cnt, n);
    cycles = cyc;
  endtask

  typedef struct {
    logic [15:0] i0, i1, i2, i3;
    int          lat;
    logic [15:0] exp_c;
    logic [4:0]  exp_f;
    logic [15:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[7];
  int   idle_bad;
  int   cycles;

  initial begin
    vecs[0] = '{16'hD005, 16'hE003, 16'h0000, 16'hD005, 1, 16'h0008, 5'b00010, 16'h0005, 16'h0003};
    vecs[1] = '{16'hD005, 16'hE005, 16'h1000, 16'hE005, 1, 16'h0000, 5'b01100, 16'h0005, 16'h0005};
    vecs[2] = '{16'hDFFF, 16'hEFFF, 16'h0000, 16'hDFFF, 1, 16'h1FFE, 5'b00100, 16'h0FFF, 16'h0FFF};
    vecs[3] = '{16'hDF0F, 16'hE0FF, 16'h2000, 16'hDF0F, 2, 16'h000F, 5'b00010, 16'h0F0F, 16'h00FF};
    vecs[4] = '{16'hD000, 16'hE001, 16'hC000, 16'hD000, 1, 16'hFFFF, 5'b00001, 16'h0000, 16'h0001};
    vecs[5] = '{16'hD001, 16'hE002, 16'h0ABC, 16'hFABC, 1, 16'h0ABC, 5'b00001, 16'h0001, 16'h0002};
    vecs[6] = '{16'hD005, 16'hE003, 16'h0000, 16'hD005, 4, 16'h0008, 5'b00010, 16'h0005, 16'h0003};
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_state", {29'b0, state_o}, 32'd0);
    check("rst_outputs", {mem_req, busy, alu_op, pc_o, reg_c_o, flags_o, alu_a}, 56'h0);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (state_o != 3'd0 || mem_req || pc_o != 12'h0 || busy) idle_bad++;
    end
    check("idle_hold", idle_bad, 0);

    // Table of 4-instruction programs
    for (int v = 0; v < 7; v++) begin
      do_reset();
      mem[0] = vecs[v].i0; mem[1] = vecs[v].i1; mem[2] = vecs[v].i2; mem[3] = vecs[v].i3;
      run(4, vecs[v].lat, 12'h000, cycles);
      check($sformatf("v%0d_cycles", v), cycles, 4 * (vecs[v].lat + 2));
      check($sformatf("v%0d_reg_c", v), {16'b0, reg_c_o}, {16'b0, vecs[v].exp_c});
      check($sformatf("v%0d_flags", v), {27'b0, flags_o}, {27'b0, vecs[v].exp_f});
      check($sformatf("v%0d_reg_a", v), {16'b0, alu_a}, {16'b0, vecs[v].exp_a});
      check($sformatf("v%0d_reg_b", v), {16'b0, alu_b}, {16'b0, vecs[v].exp_b});
      check($sformatf("v%0d_pc", v), {20'b0, pc_o}, 32'd4);
      check($sformatf("v%0d_idle", v), {28'b0, busy, state_o}, 32'd0);
    end

    // Halt after instruction 1, then resume at address 2
    do_reset();
    mem[0] = 16'hD005; mem[1] = 16'hE003; mem[2] = 16'h0000; mem[3] = 16'hD123;
    run(2, 1, 12'h000, cycles);
    check("halt_state", {29'b0, state_o}, 32'd0);
    check("halt_pc", {20'b0, pc_o}, 32'd2);
    check("halt_a", {16'b0, alu_a}, 32'h5);
    check("halt_b", {16'b0, alu_b}, 32'h3);
    check("halt_c", {16'b0, reg_c_o}, 32'h0);
    run(1, 1, 12'h002, cycles);
    check("resume_c", {16'b0, reg_c_o}, 32'h8);
    check("resume_pc", {20'b0, pc_o}, 32'd3);
    check("resume_flags", {27'b0, flags_o}, 32'b00010);

    // Asynchronous reset while a fetch is outstanding; late rvalid ignored
    auto_en = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("mf_req", {31'b0, mem_req}, 32'd1);
    check("mf_addr", {20'b0, mem_addr}, 32'd3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mf_async_state", {29'b0, state_o}, 32'd0);
    check("mf_async_req", {31'b0, mem_req}, 32'd0);
    check("mf_async_regs", {pc_o, reg_c_o, alu_a, alu_b}, 60'h0);
    @(negedge clk) rst_n = 1'b1;
    man_data  = 16'hD123;
    man_valid = 1'b1;
    @(negedge clk) man_valid = 1'b0;
    @(negedge clk);
    check("mf_post_state", {29'b0, state_o}, 32'd0);
    check("mf_post_pc", {20'b0, pc_o}, 32'd0);
    check("mf_post_regs", {reg_c_o, alu_a, alu_b, flags_o}, 53'h0);
    auto_en = 1'b1;

    // PC wrap: memory full of LOADC addr, halt with pc at 0xFFF
    for (int i = 0; i < 4096; i++) mem[i] = {4'hF, i[11:0]};
    do_reset();
    run(4095, 1, 12'h000, cycles);
    check("wrap_pre_pc", {20'b0, pc_o}, 32'hFFF);
    check("wrap_pre_c", {16'b0, reg_c_o}, 32'h0FFE);
    run(1, 1, 12'hFFF, cycles);
    check("wrap_pc", {20'b0, pc_o}, 32'h000);
    check("wrap_c", {16'b0, reg_c_o}, 32'h0FFF);
    run(1, 1, 12'h000, cycles);
    check("wrap_next_pc", {20'b0, pc_o}, 32'h001);
    check("wrap_next_c", {16'b0, reg_c_o}, 32'h0000);

    check("alu_op_idle_zero", aluop_bad, 0);
    check("mem_addr_stable", addr_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
